// File: rtl/arb_pkg.sv
// Shared encodings for the two-requester memory port arbiter.
// Holds the FSM state type and the owner encoding.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick between instruction fetch and data.
// On a tie the requester that did not own the port last time wins.
module rr_arbiter2
    import arb_pkg::*;
(
    input  logic i_if_req,
    input  logic i_d_req,
    input  logic i_last_owner,
    output logic o_valid,
    output logic o_winner
);

    always_comb begin
        o_valid = i_if_req | i_d_req;
        if (i_if_req && i_d_req) begin
            o_winner = ~i_last_owner;
        end else if (i_d_req) begin
            o_winner = OWN_D;
        end else begin
            o_winner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data accesses
// using round-robin arbitration and a fixed memory latency of MEM_LAT cycles.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        o_dbg_state
);

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t            r_state, w_state;
    logic [3:0]        r_lat_cnt, w_lat_cnt;
    logic              r_last_owner, w_last_owner;
    logic              r_if_gnt, w_if_gnt;
    logic              r_d_gnt, w_d_gnt;
    logic              r_if_done, w_if_done;
    logic              r_d_done, w_d_done;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata;
    logic [DATA_W-1:0] r_d_rdata, w_d_rdata;
    logic              r_mem_en, w_mem_en;
    logic              r_mem_we, w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;

    logic w_pick_valid;
    logic w_pick;

    rr_arbiter2 u_rr (
        .i_if_req     (if_req),
        .i_d_req      (d_req),
        .i_last_owner (r_last_owner),
        .o_valid      (w_pick_valid),
        .o_winner     (w_pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_lat_cnt    <= '0;
            r_last_owner <= OWN_IF;
            r_if_gnt     <= 1'b0;
            r_d_gnt      <= 1'b0;
            r_if_done    <= 1'b0;
            r_d_done     <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state;
            r_lat_cnt    <= w_lat_cnt;
            r_last_owner <= w_last_owner;
            r_if_gnt     <= w_if_gnt;
            r_d_gnt      <= w_d_gnt;
            r_if_done    <= w_if_done;
            r_d_done     <= w_d_done;
            r_if_rdata   <= w_if_rdata;
            r_d_rdata    <= w_d_rdata;
            r_mem_en     <= w_mem_en;
            r_mem_we     <= w_mem_we;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_lat_cnt    = r_lat_cnt;
        w_last_owner = r_last_owner;
        w_if_gnt     = r_if_gnt;
        w_d_gnt      = r_d_gnt;
        w_if_done    = 1'b0;
        w_d_done     = 1'b0;
        w_if_rdata   = r_if_rdata;
        w_d_rdata    = r_d_rdata;
        w_mem_en     = r_mem_en;
        w_mem_we     = r_mem_we;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state      = ACCESS;
                    w_last_owner = w_pick;
                    w_lat_cnt    = '0;
                    w_mem_en     = 1'b1;
                    if (w_pick == OWN_D) begin
                        w_d_gnt     = 1'b1;
                        w_mem_addr  = d_addr;
                        w_mem_we    = d_we;
                        w_mem_wdata = d_wdata;
                    end else begin
                        // Fetches are always reads regardless of d_we.
                        w_if_gnt    = 1'b1;
                        w_mem_addr  = if_addr;
                        w_mem_we    = 1'b0;
                        w_mem_wdata = '0;
                    end
                end
            end
            ACCESS: begin
                if (r_lat_cnt == LAST_CNT) begin
                    w_state  = RESP;
                    w_mem_en = 1'b0;
                    w_mem_we = 1'b0;
                    if (r_last_owner == OWN_D) begin
                        w_d_done = 1'b1;
                        if (!r_mem_we) begin
                            w_d_rdata = mem_rdata;
                        end
                    end else begin
                        w_if_done  = 1'b1;
                        w_if_rdata = mem_rdata;
                    end
                end else begin
                    w_lat_cnt = r_lat_cnt + 4'd1;
                end
            end
            RESP: begin
                w_state  = IDLE;
                w_if_gnt = 1'b0;
                w_d_gnt  = 1'b0;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign if_gnt      = r_if_gnt;
    assign d_gnt       = r_d_gnt;
    assign if_done     = r_if_done;
    assign d_done      = r_d_done;
    assign if_rdata    = r_if_rdata;
    assign d_rdata     = r_d_rdata;
    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with MEM_LAT = 2.
// A behavioural memory only drives valid read data in the last latency cycle.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:65535];
    int          mem_cnt = 0;

    mem_port_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_done     (if_done),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_done      (d_done),
        .d_rdata     (d_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Memory model: data is valid only once mem_en has been high MEM_LAT-1 edges.
    always @(posedge clk) begin
        if (rst) begin
            mem[16'h0010] <= 16'h9123;
            mem[16'h0022] <= 16'h5A5A;
        end
        if (mem_en) begin
            if (mem_we && mem_cnt == MEM_LAT - 1) begin
                mem[mem_addr] <= mem_wdata;
            end
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
    end

    assign mem_rdata = (mem_en && mem_cnt == MEM_LAT - 1) ? mem[mem_addr] : 16'hDEAD;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({if_gnt, d_gnt, if_done, d_done, mem_en, mem_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {if_gnt, d_gnt, if_done, d_done, mem_en, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_if_read();
        logic exp_gnt;
        logic exp_done;
        if_addr = 16'h0010;
        if_req  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            exp_gnt  = (k <= 3);
            exp_done = (k == 3);
            checks++;
            if (if_gnt !== exp_gnt) begin
                errors++;
                $display("FAIL if_read_gnt cycle %0d: got %b expected %b", k, if_gnt, exp_gnt);
            end
            checks++;
            if (if_done !== exp_done) begin
                errors++;
                $display("FAIL if_read_done cycle %0d: got %b expected %b", k, if_done, exp_done);
            end
            checks++;
            if (d_gnt !== 1'b0) begin
                errors++;
                $display("FAIL if_read_dgnt cycle %0d: got %b expected 0", k, d_gnt);
            end
            if (if_done) if_req = 1'b0;
        end
        checks++;
        if (if_rdata !== 16'h9123) begin
            errors++;
            $display("FAIL if_read_rdata: got %h expected 9123", if_rdata);
        end
    endtask

    task automatic test_d_store_load();
        logic exp_we;
        logic exp_done;
        bit   found;
        int   lat;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0040;
        d_wdata = 16'hBEEF;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            exp_we   = (k <= 2);
            exp_done = (k == 3);
            checks++;
            if (mem_we !== exp_we) begin
                errors++;
                $display("FAIL store_we cycle %0d: got %b expected %b", k, mem_we, exp_we);
            end
            if (k <= 2) begin
                checks++;
                if (mem_addr !== 16'h0040 || mem_wdata !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL store_addr cycle %0d: got %h/%h expected 0040/beef",
                             k, mem_addr, mem_wdata);
                end
            end
            checks++;
            if (d_done !== exp_done) begin
                errors++;
                $display("FAIL store_done cycle %0d: got %b expected %b", k, d_done, exp_done);
            end
            if (d_done) d_req = 1'b0;
        end
        d_we  = 1'b0;
        d_req = 1'b1;
        found = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 10 && !found; k++) begin
            @(posedge clk);
            #1;
            if (d_done) begin
                found = 1'b1;
                lat   = k;
                d_req = 1'b0;
            end
        end
        checks++;
        if (!found || lat != 3) begin
            errors++;
            $display("FAIL load_latency: got %0d expected 3 (found=%0d)", lat, found);
        end
        checks++;
        if (d_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL load_rdata: got %h expected beef", d_rdata);
        end
    endtask

    task automatic test_both_same_cycle();
        int d_cyc;
        int if_cyc;
        d_cyc  = -1;
        if_cyc = -1;
        do_reset();
        if_addr = 16'h0010;
        if_req  = 1'b1;
        d_addr  = 16'h0040;
        d_we    = 1'b0;
        d_req   = 1'b1;
        for (int k = 1; k <= 15 && (d_cyc < 0 || if_cyc < 0); k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                checks++;
                if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL tie_first_gnt: got d=%b if=%b expected d=1 if=0", d_gnt, if_gnt);
                end
            end
            if (d_done) begin
                d_cyc = k;
                d_req = 1'b0;
            end
            if (if_done) begin
                if_cyc = k;
                if_req = 1'b0;
            end
        end
        checks++;
        if (d_cyc != 3) begin
            errors++;
            $display("FAIL tie_d_done: got cycle %0d expected 3", d_cyc);
        end
        checks++;
        if (if_cyc - d_cyc != 4) begin
            errors++;
            $display("FAIL tie_if_after_d: got %0d cycles expected 4", if_cyc - d_cyc);
        end
        checks++;
        if (if_rdata !== 16'h9123 || d_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL tie_rdata: got %h/%h expected 9123/beef", if_rdata, d_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int   n_done;
        int   last_cyc;
        logic prev_done;
        logic [1:0] exp_done;
        n_done    = 0;
        last_cyc  = -1;
        prev_done = 1'b0;
        do_reset();
        if_addr = 16'h0010;
        d_addr  = 16'h0022;
        d_we    = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        for (int k = 1; k <= 60 && n_done < 8; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (if_gnt && d_gnt) begin
                errors++;
                $display("FAIL b2b_exclusive cycle %0d: got both gnt high expected one", k);
            end
            if (if_done || d_done) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL b2b_pulse cycle %0d: got done in consecutive cycles expected one", k);
                end
                exp_done = (n_done % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if ({if_done, d_done} !== exp_done) begin
                    errors++;
                    $display("FAIL b2b_order txn %0d: got if/d=%b expected %b",
                             n_done, {if_done, d_done}, exp_done);
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (k - last_cyc != 4) begin
                        errors++;
                        $display("FAIL b2b_spacing txn %0d: got %0d cycles expected 4",
                                 n_done, k - last_cyc);
                    end
                end
                last_cyc = k;
                n_done++;
            end
            prev_done = if_done | d_done;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        checks++;
        if (n_done != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d transactions expected 8", n_done);
        end
        checks++;
        if (if_rdata !== 16'h9123 || d_rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL b2b_rdata: got %h/%h expected 9123/5a5a", if_rdata, d_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_access();
        bit seen_done;
        bit found;
        int lat;
        d_addr = 16'h0040;
        d_we   = 1'b0;
        d_req  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (d_gnt !== 1'b1 || mem_en !== 1'b1 || dbg_state !== 2'd1) begin
            errors++;
            $display("FAIL midrst_pre: got gnt=%b en=%b st=%0d expected 1/1/1", d_gnt, mem_en, dbg_state);
        end
        rst   = 1'b1;
        d_req = 1'b0;
        #1;
        checks++;
        if ({if_gnt, d_gnt, if_done, d_done, mem_en, mem_we} !== 6'b0 ||
            {mem_addr, mem_wdata, if_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got ctrl=%b data=%h expected all 0",
                     {if_gnt, d_gnt, if_done, d_done, mem_en, mem_we},
                     {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL midrst_state: got %0d expected 0", dbg_state);
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (if_done || d_done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL midrst_no_done: got done during reset expected none");
        end
        rst     = 1'b0;
        if_addr = 16'h0010;
        if_req  = 1'b1;
        found   = 1'b0;
        lat     = 0;
        for (int k = 1; k <= 10 && !found; k++) begin
            @(posedge clk);
            #1;
            if (if_done) begin
                found  = 1'b1;
                lat    = k;
                if_req = 1'b0;
            end
        end
        checks++;
        if (!found || lat != 3 || if_rdata !== 16'h9123) begin
            errors++;
            $display("FAIL midrst_recover: got lat=%0d rdata=%h expected 3/9123", lat, if_rdata);
        end
    endtask

    task automatic test_drop_mid_access();
        int if_cyc;
        int d_cyc;
        if_cyc = -1;
        d_cyc  = -1;
        @(posedge clk);
        #1;
        if_addr = 16'h0022;
        if_req  = 1'b1;
        for (int k = 1; k <= 12 && d_cyc < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                checks++;
                if (if_gnt !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_gnt: got %b expected 1", if_gnt);
                end
                if_req = 1'b0;
                d_addr = 16'h0040;
                d_we   = 1'b0;
                d_req  = 1'b1;
            end
            if (k == 5) begin
                checks++;
                if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_next_gnt: got d=%b if=%b expected d=1 if=0", d_gnt, if_gnt);
                end
            end
            if (if_done) if_cyc = k;
            if (d_done) begin
                d_cyc = k;
                d_req = 1'b0;
            end
        end
        checks++;
        if (if_cyc != 3 || if_rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL drop_if_done: got cycle %0d rdata %h expected 3/5a5a", if_cyc, if_rdata);
        end
        checks++;
        if (d_cyc != 7 || d_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL drop_d_done: got cycle %0d rdata %h expected 7/beef", d_cyc, d_rdata);
        end
    endtask

    initial begin
        rst     = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        test_reset();
        test_single_if_read();
        test_d_store_load();
        test_both_same_cycle();
        test_back_to_back();
        test_reset_mid_access();
        test_drop_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, byte-addressed 16-bit memory between two requesters in the multi-cycle processor: instruction fetch (IF) and data load/store (D).
- Lets the processor use one unified memory in place of separate instruction and data memories.
- Uses round-robin arbitration, a registered request/grant/done handshake, and a fixed programmable memory latency.
- Sits between the control unit's ImRead/MemRead/MemWrite paths and the memory macro.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data width in bits.
- MEM_LAT, 2, cycles the memory needs from mem_en to valid mem_rdata; legal range is 1 to 15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- if_req  in  1  IF read request; held high until if_done.
- if_addr  in  ADDR_W  IF address (PC).
- if_gnt  out  1  IF owns the memory port.
- if_done  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  fetched instruction word.
- d_req  in  1  data request; held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address (ALUOut).
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  D owns the memory port.
- d_done  out  1  one-cycle pulse; load data in d_rdata.
- d_rdata  out  DATA_W  load data (MDR input).
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en rises.

Behaviour:
- Reset: all outputs are registered and clear to 0. State = IDLE, lat_cnt = 0, last_owner = IF, so D wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples requests at each edge.
  - With exactly one req high, that requester wins.
  - With both high, the requester that is not last_owner wins.
  - On a win: latch addr, we and wdata into mem_addr, mem_we, mem_wdata. Set the winner's gnt = 1 and mem_en = 1, update last_owner, clear lat_cnt, go to ACCESS.
- ACCESS:
  - mem_en and the mem_* outputs stay stable. lat_cnt increments each cycle.
  - When lat_cnt == MEM_LAT-1:
    - Load: capture mem_rdata into the winner's rdata register.
    - Store: the rdata register is unchanged.
    - Drop mem_en and mem_we, assert the winner's done, go to RESP.
- RESP:
  - done is high for exactly this one cycle; gnt stays high.
  - On exit: gnt = 0, done = 0, go to IDLE.
  - A new grant is possible at the next IDLE edge.
- Latency with req high before edge E0:
  - gnt rises after E0.
  - mem_en is high for MEM_LAT cycles.
  - done is high after edge E(MEM_LAT) for one cycle.
  - Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Exclusivity: if_gnt and d_gnt are never high together. mem_en is high only in ACCESS.
- Request dropped mid-transaction:
  - Not legal for requesters.
  - The arbiter still completes the access and pulses done; it never aborts.
- Request changes while not granted: ignored until sampled in IDLE.
- d_we is ignored for IF; IF accesses are always reads.
- Address is passed through unchanged with no alignment check. Byte ordering is the memory's concern.
- rdata registers hold their last value until the next completion for that requester.
- Reset mid-ACCESS: immediate return to the reset state. mem_en and mem_we drop asynchronously, no done is issued, and a pending store may be partial or absent.
- Starvation bound: with both requesters continuously active, each is granted at least once every 2×(MEM_LAT+2) cycles.

Decomposition:
- Shared package (arb_pkg) holds:
  - State encoding localparams: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Owner encoding: OWN_IF = 1'b0, OWN_D = 1'b1.
- Natural sub-module: rr_arbiter2, combinational two-way round-robin pick from (if_req, d_req, last_owner).
- The FSM, latency counter and datapath registers stay in the top module.

Test Plan (all with MEM_LAT = 2):
- Reset then single IF read (if_addr = 0x0010, memory returns 0x9123):
  - if_gnt is high for cycles 1–3 and if_done is high in cycle 3.
  - if_rdata = 0x9123; d_gnt stays 0 throughout.
- D store (d_addr = 0x0040, d_wdata = 0xBEEF):
  - mem_we = 1 and mem_addr = 0x0040 for exactly 2 cycles, then d_done pulses.
  - A subsequent D load of 0x0040 returns 0xBEEF.
- Both requests rise in the same cycle right after reset:
  - D is served first and IF follows.
  - if_done occurs exactly 4 cycles after d_done.
- Both requesters held continuously for 8 transactions:
  - Grants alternate IF/D.
  - The two gnt signals are never high together; each done is a single-cycle pulse.
- Assert rst during cycle 2 of a load:
  - All outputs go to 0 immediately, no done is issued, and the FSM is in IDLE.
  - After release, a fresh request completes normally.
- if_req dropped mid-ACCESS:
  - The transaction still completes and if_done still pulses.
  - The next grant goes to a waiting d_req.
